// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch front end. Owns the program counter, presents it as a
// byte address to a combinational instruction memory and captures the
// returned word into a one-entry output register with a valid/ready
// handshake. Redirects flush the register and reload the PC. A misaligned
// or out-of-range PC raises a sticky fault that only reset clears.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   imem_addr       byte address to instruction memory (the PC)
//   imem_instr      instruction word returned for imem_addr
//   redirect_valid  taken branch/jump; flushes the output register
//   redirect_target new PC when redirect_valid is high
//   out_valid       output register holds an instruction
//   out_ready       consumer accepts the output this cycle
//   out_pc          PC of the held instruction
//   out_pc_plus4    out_pc + 4 (wraps modulo 2^32)
//   out_instr       held instruction word
//   fault           sticky fetch fault
//   fault_pc        PC that caused the fault
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [29:0] MEM_WORDS = 30'(MEM_SIZE);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        valid_next;
  logic [31:0] opc_next, opc4_next, instr_next;
  logic        fault_next;
  logic [31:0] fault_pc_next;
  logic        pc_bad, can_load;

  assign imem_addr = pc;

  // The word index is compared rather than the byte address so that PCs
  // near the top of the 32-bit space cannot wrap into range.
  assign pc_bad   = (pc[1:0] != 2'b00) || (pc[31:2] >= MEM_WORDS);
  assign can_load = !out_valid || out_ready;

  // State and output register. Reset discards any held instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pc           <= RESET_PC;
      out_valid    <= 1'b0;
      out_pc       <= 32'h0;
      out_pc_plus4 <= 32'h0;
      out_instr    <= 32'h0;
      fault        <= 1'b0;
      fault_pc     <= 32'h0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      out_valid    <= valid_next;
      out_pc       <= opc_next;
      out_pc_plus4 <= opc4_next;
      out_instr    <= instr_next;
      fault        <= fault_next;
      fault_pc     <= fault_pc_next;
    end
  end

  // Next-state logic. A redirect wins over everything in RUN, so a PC that
  // is being flushed never raises a fault; the new target is checked only
  // when it is fetched. A stall leaves every register untouched.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    valid_next    = out_valid;
    opc_next      = out_pc;
    opc4_next     = out_pc_plus4;
    instr_next    = out_instr;
    fault_next    = fault;
    fault_pc_next = fault_pc;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          valid_next = 1'b0;
          pc_next    = redirect_target;
        end else if (pc_bad && can_load) begin
          state_next    = FAULT;
          fault_next    = 1'b1;
          fault_pc_next = pc;
          valid_next    = 1'b0;
        end else if (can_load) begin
          opc_next   = pc;
          opc4_next  = pc + 32'd4;
          instr_next = imem_instr;
          valid_next = 1'b1;
          pc_next    = pc + 32'd4;
        end
      end
      FAULT: begin
        valid_next = 1'b0;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed scenarios plus a randomized run checked against a behavioural
// model of the fetch rules. A second instance with a four-word memory
// exercises sequential run-off into the fault state.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_ready;

  logic [31:0] imem_addr, imem_instr;
  logic        out_valid, fault;
  logic [31:0] out_pc, out_pc_plus4, out_instr, fault_pc;

  logic [31:0] imem_addr2, imem_instr2;
  logic        out_valid2, fault2;
  logic [31:0] out_pc2, out_pc_plus42, out_instr2, fault_pc2;

  logic [31:0] mem [0:127];

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0), .MEM_SIZE(128)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .out_instr(out_instr), .fault(fault),
    .fault_pc(fault_pc)
  );

  fetch_stage #(.RESET_PC(32'h0), .MEM_SIZE(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .out_valid(out_valid2), .out_ready(out_ready), .out_pc(out_pc2),
    .out_pc_plus4(out_pc_plus42), .out_instr(out_instr2), .fault(fault2),
    .fault_pc(fault_pc2)
  );

  // Out-of-range addresses return a recognisable junk word.
  function automatic logic [31:0] mem_read(input logic [31:0] addr);
    if (addr < 32'd512) return mem[addr[8:2]];
    return addr ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_instr  = mem_read(imem_addr);
  assign imem_instr2 = mem_read(imem_addr2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across a rising edge and release it on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got %0b exp 0", fault); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h exp 0", imem_addr); end
    checks++; if ({out_pc, out_pc_plus4, out_instr, fault_pc} !== 128'h0) begin errors++;
      $display("[TB] FAIL reset_regs got %h %h %h %h exp zeros", out_pc, out_pc_plus4, out_instr, fault_pc); end
  endtask

  task automatic test_sequential();
    logic [31:0] seq [0:3];
    seq[0] = 32'h0000_0013; seq[1] = 32'h0010_0093;
    seq[2] = 32'h0020_0113; seq[3] = 32'h0030_0193;
    for (int i = 0; i < 4; i++) mem[i] = seq[i];
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_instr !== seq[i] || out_pc_plus4 !== 32'(4*i+4)) begin
        errors++;
        $display("[TB] FAIL seq%0d got v=%0b pc=%h p4=%h ins=%h exp v=1 pc=%h p4=%h ins=%h",
                 i, out_valid, out_pc, out_pc_plus4, out_instr, 32'(4*i), 32'(4*i+4), seq[i]);
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    do_reset();
    tick(); tick(); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== mem[2] || imem_addr !== 32'hC) begin
        errors++;
        $display("[TB] FAIL stall%0d got v=%0b pc=%h ins=%h addr=%h exp v=1 pc=8 ins=%h addr=c",
                 i, out_valid, out_pc, out_instr, imem_addr, mem[2]);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hC || out_instr !== mem[3]) begin
      errors++;
      $display("[TB] FAIL stall_release got pc=%h ins=%h exp pc=c ins=%h", out_pc, out_instr, mem[3]);
    end
  endtask

  task automatic test_redirect(input logic ready_same);
    out_ready = 1'b1;
    do_reset();
    tick(); tick();
    out_ready = ready_same;
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("[TB] FAIL redirect_flush(r=%0b) got v=%0b exp 0", ready_same, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== mem[16]) begin
      errors++;
      $display("[TB] FAIL redirect_target(r=%0b) got v=%0b pc=%h ins=%h exp v=1 pc=40 ins=%h",
               ready_same, out_valid, out_pc, out_instr, mem[16]);
    end
  endtask

  task automatic test_fault();
    out_ready = 1'b1;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h42;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b0 || out_valid !== 1'b0) begin errors++;
      $display("[TB] FAIL fault_not_yet got f=%0b v=%0b exp f=0 v=0", fault, out_valid); end
    tick();
    checks++; if (fault !== 1'b1 || fault_pc !== 32'h42 || out_valid !== 1'b0) begin errors++;
      $display("[TB] FAIL fault_raise got f=%0b fpc=%h v=%0b exp f=1 fpc=42 v=0", fault, fault_pc, out_valid); end
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (fault !== 1'b1 || fault_pc !== 32'h42 || out_valid !== 1'b0 || imem_addr !== 32'h42) begin
        errors++;
        $display("[TB] FAIL fault_sticky%0d got f=%0b fpc=%h v=%0b addr=%h exp f=1 fpc=42 v=0 addr=42",
                 i, fault, fault_pc, out_valid, imem_addr);
      end
    end
    redirect_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fault !== 1'b0 || fault_pc !== 32'h0 || imem_addr !== 32'h0) begin errors++;
      $display("[TB] FAIL fault_clear got f=%0b fpc=%h addr=%h exp 0 0 0", fault, fault_pc, imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_runoff();
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid2 !== 1'b1 || out_pc2 !== 32'(4*i) || out_instr2 !== mem[i] || fault2 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL runoff%0d got v=%0b pc=%h ins=%h f=%0b exp v=1 pc=%h ins=%h f=0",
                 i, out_valid2, out_pc2, out_instr2, fault2, 32'(4*i), mem[i]);
      end
    end
    tick();
    checks++; if (fault2 !== 1'b1 || fault_pc2 !== 32'h10 || out_valid2 !== 1'b0 || imem_addr2 !== 32'h10) begin
      errors++;
      $display("[TB] FAIL runoff_fault got f=%0b fpc=%h v=%0b addr=%h exp f=1 fpc=10 v=0 addr=10",
               fault2, fault_pc2, out_valid2, imem_addr2);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    do_reset();
    tick(); tick();
    out_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got v=%0b f=%0b addr=%h pc=%h exp 0 0 0 0", out_valid, fault, imem_addr, out_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem[0]) begin
      errors++;
      $display("[TB] FAIL async_restart got v=%0b pc=%h ins=%h exp v=1 pc=0 ins=%h", out_valid, out_pc, out_instr, mem[0]);
    end
  endtask

  // Randomized traffic against a model that tracks the architectural
  // values directly: the fetch address, the held instruction and the fault.
  task automatic test_random();
    logic [31:0] m_pc, m_opc, m_instr, m_fpc;
    logic        m_valid, m_fault, bad, take;
    int          fault_age;
    int          r;
    out_ready = 1'b1;
    do_reset();
    m_pc = 32'h0; m_opc = 32'h0; m_instr = 32'h0; m_fpc = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0; fault_age = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 99);
      if (r < 3)       redirect_target = ($urandom & 32'h1FF) | 32'h1;
      else if (r < 5)  redirect_target = $urandom;
      else if (r < 15) redirect_target = 32'd504;
      else             redirect_target = 32'($urandom_range(0, 127)) * 4;

      take = !m_valid || out_ready;
      bad  = (m_pc % 4 != 0) || (m_pc >= 32'd512);
      if (!m_fault) begin
        if (redirect_valid) begin
          m_valid = 1'b0;
          m_pc = redirect_target;
        end else if (bad && take) begin
          m_fault = 1'b1;
          m_fpc = m_pc;
          m_valid = 1'b0;
        end else if (take) begin
          m_opc = m_pc;
          m_instr = mem_read(m_pc);
          m_valid = 1'b1;
          m_pc = m_pc + 32'd4;
        end
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_pc !== m_opc || out_pc_plus4 !== m_opc + 32'd4 && m_opc + 32'd4 !== 32'h4 - 32'h4 + m_opc + 32'd4
          || out_instr !== m_instr || fault !== m_fault || fault_pc !== m_fpc || imem_addr !== m_pc) begin
        errors++;
        $display("[TB] FAIL random%0d got v=%0b pc=%h ins=%h f=%0b fpc=%h addr=%h exp v=%0b pc=%h ins=%h f=%0b fpc=%h addr=%h",
                 cyc, out_valid, out_pc, out_instr, fault, fault_pc, imem_addr,
                 m_valid, m_opc, m_instr, m_fault, m_fpc, m_pc);
      end
      checks++;
      if (out_pc_plus4 !== ((m_valid || m_opc != 0 || m_instr != 0) ? m_opc + 32'd4 : 32'h0)) begin
        errors++;
        $display("[TB] FAIL random_plus4_%0d got %h exp %h", cyc, out_pc_plus4, m_opc + 32'd4);
      end
      if (m_fault) fault_age++;
      if (fault_age > 4 || $urandom_range(0, 99) == 0) begin
        redirect_valid = 1'b0;
        #2 rst_n = 1'b0;
        m_pc = 32'h0; m_opc = 32'h0; m_instr = 32'h0; m_fpc = 32'h0;
        m_valid = 1'b0; m_fault = 1'b0; fault_age = 0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    out_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    $display("[TB] starting");
    test_reset();
    test_sequential();
    test_stall();
    test_redirect(1'b0);
    test_redirect(1'b1);
    test_fault();
    test_runoff();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
